bypass_rx_slot_ctrl: RTL

Slot allocator and flow controller for the raw-Ethernet bypass RX circular buffer in host memory.
- Assigns each received packet a PMTU-sized slot address and emits the write descriptor fields.
- Tracks slots still unconsumed by software, accepting consume-count updates from the host side.
- On overflow, either backpressures the RX descriptor path or drops and counts, per parameter.

---
 rtl/bypass_rx_slot_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/bypass_rx_slot_ctrl.sv
// Slot allocator and flow controller for the raw-Ethernet bypass RX circular buffer.
// Hands out PMTU-sized slots, tracks unconsumed slots, and backpressures or drops on overflow.
module bypass_rx_slot_ctrl #(
  parameter int NUM_SLOTS    = 1024,
  parameter int SLOT_BYTES   = 4096,
  parameter int VADDR_BITS   = 48,
  parameter int LEN_BITS     = 28,
  parameter int DROP_ON_FULL = 0,
  localparam int IDX_BITS    = $clog2(NUM_SLOTS)
) (
  input  logic                  nclk,
  input  logic                  nresetn,
  input  logic                  cfg_valid,
  input  logic [VADDR_BITS-1:0] cfg_base,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [LEN_BITS-1:0]   req_len,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [VADDR_BITS-1:0] rsp_vaddr,
  output logic [LEN_BITS-1:0]   rsp_len,
  output logic [IDX_BITS-1:0]   rsp_slot,
  output logic                  rsp_drop,
  input  logic                  free_valid,
  input  logic [IDX_BITS:0]     free_count,
  output logic [IDX_BITS:0]     occupancy,
  output logic                  full,
  output logic [31:0]           drop_count,
  output logic                  err_pulse
);

  localparam int SLOT_SHIFT = $clog2(SLOT_BYTES);

  typedef enum logic [1:0] {UNCFG, RUN, HOLD} state_t;

  state_t                  state_reg;
  logic [1:0]              rst_sync_reg;
  logic                    rst_n;
  logic [VADDR_BITS-1:0]   base_reg;
  logic [IDX_BITS-1:0]     wr_idx_reg;
  logic [IDX_BITS:0]       occupancy_reg;
  logic [VADDR_BITS-1:0]   rsp_vaddr_reg;
  logic [LEN_BITS-1:0]     rsp_len_reg;
  logic [IDX_BITS-1:0]     rsp_slot_reg;
  logic                    rsp_valid_reg;
  logic                    rsp_drop_reg;
  logic [31:0]             drop_count_reg;
  logic                    err_reg;

  logic                    full_now;
  logic                    accept;
  logic                    alloc;
  logic                    len_over;
  logic                    free_en;
  logic                    free_over;
  logic [IDX_BITS:0]       occ_sum;
  logic [IDX_BITS:0]       occupancy_next;
  logic [VADDR_BITS-1:0]   slot_offset;

  // Reset asserts immediately but releases synchronously to nclk.
  always_ff @(posedge nclk or negedge nresetn) begin
    if (!nresetn) rst_sync_reg <= 2'b00;
    else          rst_sync_reg <= {rst_sync_reg[0], 1'b1};
  end
  assign rst_n = rst_sync_reg[1];

  assign full_now  = (occupancy_reg == (IDX_BITS+1)'(NUM_SLOTS));
  assign req_ready = ((state_reg == RUN) || ((state_reg == HOLD) && rsp_ready))
                     && (!full_now || (DROP_ON_FULL != 0)) && !cfg_valid;
  assign accept    = req_valid && req_ready;
  assign alloc     = accept && !full_now;
  assign len_over  = (req_len > LEN_BITS'(SLOT_BYTES));
  assign free_en   = free_valid && (state_reg != UNCFG) && !cfg_valid;
  assign occ_sum   = occupancy_reg + (IDX_BITS+1)'(alloc);
  assign free_over = free_en && (free_count > occ_sum);
  assign slot_offset = VADDR_BITS'(wr_idx_reg) << SLOT_SHIFT;

  // Release is clamped against the post-allocation count.
  always_comb begin
    occupancy_next = occ_sum;
    if (free_en) begin
      if (free_over) occupancy_next = '0;
      else           occupancy_next = occ_sum - free_count;
    end
  end

  always_ff @(posedge nclk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= UNCFG;
      base_reg       <= '0;
      wr_idx_reg     <= '0;
      occupancy_reg  <= '0;
      rsp_valid_reg  <= 1'b0;
      rsp_vaddr_reg  <= '0;
      rsp_len_reg    <= '0;
      rsp_slot_reg   <= '0;
      rsp_drop_reg   <= 1'b0;
      drop_count_reg <= '0;
      err_reg        <= 1'b0;
    end else if (cfg_valid) begin
      state_reg     <= RUN;
      base_reg      <= cfg_base;
      wr_idx_reg    <= '0;
      occupancy_reg <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_drop_reg  <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      err_reg       <= (accept && len_over) || free_over;
      occupancy_reg <= occupancy_next;
      if (accept) begin
        state_reg     <= HOLD;
        rsp_valid_reg <= 1'b1;
        rsp_vaddr_reg <= base_reg + slot_offset;
        rsp_slot_reg  <= wr_idx_reg;
        rsp_len_reg   <= len_over ? LEN_BITS'(SLOT_BYTES) : req_len;
        rsp_drop_reg  <= !alloc;
        if (alloc) begin
          wr_idx_reg <= wr_idx_reg + 1'b1;
        end else if (drop_count_reg != 32'hFFFF_FFFF) begin
          drop_count_reg <= drop_count_reg + 32'd1;
        end
      end else if ((state_reg == HOLD) && rsp_ready) begin
        state_reg     <= RUN;
        rsp_valid_reg <= 1'b0;
      end
    end
  end

  assign rsp_valid  = rsp_valid_reg;
  assign rsp_vaddr  = rsp_vaddr_reg;
  assign rsp_len    = rsp_len_reg;
  assign rsp_slot   = rsp_slot_reg;
  assign rsp_drop   = rsp_drop_reg;
  assign occupancy  = occupancy_reg;
  assign full       = full_now;
  assign drop_count = drop_count_reg;
  assign err_pulse  = err_reg;

endmodule
